fl_frame_checker: RTL

FrameLink in-line checking stage placed directly downstream of the FrameLink FIFO read side. It forwards frames unchanged through one register slice with full throughput, and checks each frame for protocol consistency and part structure (PARTS parts per frame, bounded part length). It also exposes frame/error statistics for the bench and for status registers.

---
 rtl/fl_checker_pkg.sv | 22 ++
 rtl/fl_reg_slice.sv | 73 +++++++
 rtl/fl_frame_checker.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fl_checker_pkg.sv
// Shared definitions for the FrameLink frame checker: FSM state encoding
// and the data-width to bytes-per-word helper.
package fl_checker_pkg;

  // state     | meaning
  // S_IDLE    | between frames, next word must carry SOF+SOP
  // S_IN_PART | inside a part, waiting for EOP
  // S_GAP     | part closed by EOP, next word must carry SOP
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IN_PART = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  // Part counter width; saturates, so frames with absurd part counts still flag.
  localparam int PART_CNT_WIDTH = 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/fl_reg_slice.sv
// One-stage FrameLink register slice. Ready while empty or draining, so a
// single register sustains one word per cycle without a skid buffer.
module fl_reg_slice #(
  parameter int DATA_WIDTH = 64,
  parameter int DREM_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DREM_WIDTH-1:0] i_rx_drem,
  input  logic                  i_rx_sof_n,
  input  logic                  i_rx_eof_n,
  input  logic                  i_rx_sop_n,
  input  logic                  i_rx_eop_n,
  input  logic                  i_rx_src_rdy_n,
  output logic                  o_rx_dst_rdy_n,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [DREM_WIDTH-1:0] o_tx_drem,
  output logic                  o_tx_sof_n,
  output logic                  o_tx_eof_n,
  output logic                  o_tx_sop_n,
  output logic                  o_tx_eop_n,
  output logic                  o_tx_src_rdy_n,
  input  logic                  i_tx_dst_rdy_n
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DREM_WIDTH-1:0] r_drem;
  logic                  r_sof_n;
  logic                  r_eof_n;
  logic                  r_sop_n;
  logic                  r_eop_n;
  logic                  w_rx_dst_rdy_n;
  logic                  w_rx_xfer;

  // Held not-ready during reset so nothing is accepted while the slice clears.
  assign w_rx_dst_rdy_n = ~i_reset_n | (r_valid & i_tx_dst_rdy_n);
  assign w_rx_xfer      = ~i_rx_src_rdy_n & ~w_rx_dst_rdy_n;

  // Load on input transfer, empty on output transfer with nothing new arriving.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_drem  <= '0;
      r_sof_n <= 1'b1;
      r_eof_n <= 1'b1;
      r_sop_n <= 1'b1;
      r_eop_n <= 1'b1;
    end else if (w_rx_xfer) begin
      r_valid <= 1'b1;
      r_data  <= i_rx_data;
      r_drem  <= i_rx_drem;
      r_sof_n <= i_rx_sof_n;
      r_eof_n <= i_rx_eof_n;
      r_sop_n <= i_rx_sop_n;
      r_eop_n <= i_rx_eop_n;
    end else if (!i_tx_dst_rdy_n) begin
      r_valid <= 1'b0;
    end
  end

  assign o_rx_dst_rdy_n = w_rx_dst_rdy_n;
  assign o_tx_data      = r_data;
  assign o_tx_drem      = r_drem;
  assign o_tx_sof_n     = r_sof_n;
  assign o_tx_eof_n     = r_eof_n;
  assign o_tx_sop_n     = r_sop_n;
  assign o_tx_eop_n     = r_eop_n;
  assign o_tx_src_rdy_n = ~r_valid;

endmodule

// File: rtl/fl_frame_checker.sv
// FrameLink in-line frame checker: forwards words through a register slice
// and tracks frame/part structure on accepted input words, raising sticky
// error flags and frame/length statistics. Errors never block forwarding.
module fl_frame_checker
  import fl_checker_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DREM_WIDTH   = $clog2(DATA_WIDTH / 8),
  parameter int PARTS        = 3,
  parameter int PART_LEN_MAX = 1536,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DREM_WIDTH-1:0] i_rx_drem,
  input  logic                  i_rx_sof_n,
  input  logic                  i_rx_eof_n,
  input  logic                  i_rx_sop_n,
  input  logic                  i_rx_eop_n,
  input  logic                  i_rx_src_rdy_n,
  output logic                  o_rx_dst_rdy_n,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [DREM_WIDTH-1:0] o_tx_drem,
  output logic                  o_tx_sof_n,
  output logic                  o_tx_eof_n,
  output logic                  o_tx_sop_n,
  output logic                  o_tx_eop_n,
  output logic                  o_tx_src_rdy_n,
  input  logic                  i_tx_dst_rdy_n,
  output logic [31:0]           o_frame_cnt,
  output logic [LEN_WIDTH-1:0]  o_last_len,
  output logic                  o_err_sof,
  output logic                  o_err_parts,
  output logic                  o_err_len,
  input  logic                  i_err_clr
);

  localparam logic [LEN_WIDTH-1:0]      C_BPW     = LEN_WIDTH'(bytes_per_word(DATA_WIDTH));
  localparam logic [LEN_WIDTH-1:0]      C_LEN_MAX = LEN_WIDTH'(PART_LEN_MAX);
  localparam logic [PART_CNT_WIDTH-1:0] C_PARTS   = PART_CNT_WIDTH'(PARTS);

  logic                      w_rx_dst_rdy_n;
  logic                      w_rx_xfer;
  logic                      w_sof, w_eof, w_sop, w_eop;
  logic                      w_new_frame;
  logic                      w_new_part;
  logic                      w_end_part;
  logic [LEN_WIDTH-1:0]      w_word_bytes;
  logic [LEN_WIDTH-1:0]      w_len_base;
  logic [LEN_WIDTH:0]        w_len_sum;
  logic [LEN_WIDTH-1:0]      w_len_nxt;
  logic [PART_CNT_WIDTH-1:0] w_parts_nxt;
  logic                      w_err_sof_set;
  logic                      w_err_parts_set;
  logic                      w_err_len_set;
  state_t                    w_state_nxt;

  state_t                    r_state;
  logic [PART_CNT_WIDTH-1:0] r_parts;
  logic [LEN_WIDTH-1:0]      r_len;
  logic [31:0]               r_frame_cnt;
  logic [LEN_WIDTH-1:0]      r_last_len;
  logic                      r_err_sof;
  logic                      r_err_parts;
  logic                      r_err_len;

  fl_reg_slice #(
    .DATA_WIDTH (DATA_WIDTH),
    .DREM_WIDTH (DREM_WIDTH)
  ) u_slice (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_rx_data      (i_rx_data),
    .i_rx_drem      (i_rx_drem),
    .i_rx_sof_n     (i_rx_sof_n),
    .i_rx_eof_n     (i_rx_eof_n),
    .i_rx_sop_n     (i_rx_sop_n),
    .i_rx_eop_n     (i_rx_eop_n),
    .i_rx_src_rdy_n (i_rx_src_rdy_n),
    .o_rx_dst_rdy_n (w_rx_dst_rdy_n),
    .o_tx_data      (o_tx_data),
    .o_tx_drem      (o_tx_drem),
    .o_tx_sof_n     (o_tx_sof_n),
    .o_tx_eof_n     (o_tx_eof_n),
    .o_tx_sop_n     (o_tx_sop_n),
    .o_tx_eop_n     (o_tx_eop_n),
    .o_tx_src_rdy_n (o_tx_src_rdy_n),
    .i_tx_dst_rdy_n (i_tx_dst_rdy_n)
  );

  assign o_rx_dst_rdy_n = w_rx_dst_rdy_n;
  assign w_rx_xfer      = ~i_rx_src_rdy_n & ~w_rx_dst_rdy_n;

  // Next-state, counter and error-set decode for the word currently offered.
  // A word in S_IDLE always opens a frame (resync) and an unmarked word in
  // S_GAP always opens a part, so counting keeps going after a protocol slip.
  always_comb begin
    w_sof       = ~i_rx_sof_n;
    w_eof       = ~i_rx_eof_n;
    w_sop       = ~i_rx_sop_n;
    w_eop       = ~i_rx_eop_n;
    w_new_frame = (r_state == S_IDLE) || w_sof;
    w_new_part  = w_new_frame || w_sop || (r_state == S_GAP);
    w_end_part  = w_eop || w_eof;

    w_word_bytes = w_eop ? (LEN_WIDTH'(i_rx_drem) + LEN_WIDTH'(1)) : C_BPW;
    w_len_base   = w_new_part ? '0 : r_len;
    w_len_sum    = {1'b0, w_len_base} + {1'b0, w_word_bytes};
    w_len_nxt    = w_len_sum[LEN_WIDTH] ? '1 : w_len_sum[LEN_WIDTH-1:0];

    w_parts_nxt = r_parts;
    if (w_new_frame) begin
      w_parts_nxt = PART_CNT_WIDTH'(1);
    end else if (w_new_part && (r_parts != '1)) begin
      w_parts_nxt = r_parts + PART_CNT_WIDTH'(1);
    end

    w_err_sof_set   = w_rx_xfer && ((r_state == S_IDLE) ? !w_sof : w_sof);
    w_err_parts_set = w_rx_xfer &&
                      ((w_sof && !w_sop) ||
                       (w_eof && !w_eop) ||
                       ((r_state == S_GAP) && !w_sof && !w_sop) ||
                       (w_eof && (w_parts_nxt != C_PARTS)));
    w_err_len_set   = w_rx_xfer && w_end_part && (w_len_nxt > C_LEN_MAX);

    if (w_eof) begin
      w_state_nxt = S_IDLE;
    end else if (w_eop) begin
      w_state_nxt = S_GAP;
    end else begin
      w_state_nxt = S_IN_PART;
    end
  end

  // Frame-structure FSM with part/byte counters, statistics and sticky flags.
  // A new error outranks a coincident clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_parts     <= '0;
      r_len       <= '0;
      r_frame_cnt <= '0;
      r_last_len  <= '0;
      r_err_sof   <= 1'b0;
      r_err_parts <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      if (w_rx_xfer) begin
        r_state <= w_state_nxt;
        r_parts <= w_parts_nxt;
        r_len   <= w_len_nxt;
        if (w_end_part) begin
          r_last_len <= w_len_nxt;
        end
        if (w_eof) begin
          r_frame_cnt <= r_frame_cnt + 32'd1;
        end
      end
      r_err_sof   <= (r_err_sof   & ~i_err_clr) | w_err_sof_set;
      r_err_parts <= (r_err_parts & ~i_err_clr) | w_err_parts_set;
      r_err_len   <= (r_err_len   & ~i_err_clr) | w_err_len_set;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_last_len  = r_last_len;
  assign o_err_sof   = r_err_sof;
  assign o_err_parts = r_err_parts;
  assign o_err_len   = r_err_len;

endmodule
